// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiply/divide units that plug into one ALU sequencer.
// Holds the common 3-bit state encoding, the default operand width and a busy decode helper.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Handshake shared with the divider: start is sampled only in IDLE and accepted on
  // that edge; busy is high from LOAD through ADD; done pulses for exactly one cycle in
  // DONE_ST, and the result is valid from that same cycle. A start seen while busy or
  // in DONE_ST is dropped, not queued.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    CHECK_ZERO = 3'd2,
    CHECK      = 3'd3,
    ADD        = 3'd4,
    DONE_ST    = 3'd5
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s == LOAD) || (s == CHECK_ZERO) || (s == CHECK) || (s == ADD);
  endfunction

endpackage

// File: rtl/mult_seq_add_control_mult.sv
// Control FSM for the add-and-decrement multiplier.
// Produces datapath strobes and the start/busy/done handshake, all decoded from state.
module control_mult
  import mult_div_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   start,
  input  logic   cnt_zero,
  output logic   load,
  output logic   add,
  output logic   p_load,
  output logic   busy,
  output logic   done,
  output state_e state_o
);

  state_e state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:       if (start) state_q <= LOAD;
        LOAD:       state_q <= CHECK_ZERO;
        CHECK_ZERO: state_q <= cnt_zero ? DONE_ST : CHECK;
        CHECK:      state_q <= cnt_zero ? DONE_ST : ADD;
        ADD:        state_q <= CHECK;
        DONE_ST:    state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  // p_load marks the edge that enters DONE_ST, so the product lands together with done.
  assign load    = (state_q == IDLE) && start;
  assign add     = (state_q == ADD);
  assign p_load  = ((state_q == CHECK_ZERO) || (state_q == CHECK)) && cnt_zero;
  assign busy    = state_is_busy(state_q);
  assign done    = (state_q == DONE_ST);
  assign state_o = state_q;

endmodule

// File: rtl/mult_seq_add.sv
// Unsigned sequential multiplier by repeated addition of the larger operand.
// Iterating over the smaller operand bounds latency at 3+2*min(A,B) edges.
module mult_seq_add
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  logic [WIDTH-1:0]   big_q, big_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic   load, add, p_load, cnt_zero;
  state_e state;

  assign cnt_zero = (cnt_q == '0);

  control_mult u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .cnt_zero (cnt_zero),
    .load     (load),
    .add      (add),
    .p_load   (p_load),
    .busy     (busy),
    .done     (done),
    .state_o  (state)
  );

  always_comb begin
    big_d = big_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    p_d   = p_q;
    if (load) begin
      // Count down the smaller operand; A and B are free to change after this edge.
      if (A >= B) begin
        big_d = A;
        cnt_d = B;
      end else begin
        big_d = B;
        cnt_d = A;
      end
      acc_d = '0;
    end else if (add) begin
      // acc is 2*WIDTH wide, so (2^W-1)^2 always fits; add is never issued with cnt==0.
      acc_d = acc_q + {{WIDTH{1'b0}}, big_q};
      cnt_d = cnt_q - WIDTH'(1);
    end
    if (p_load) begin
      p_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      big_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      p_q   <= '0;
    end else begin
      big_q <= big_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      p_q   <= p_d;
    end
  end

  assign P = p_q;

endmodule
